// File: rtl/cic_comp_fir_pkg.sv
// Shared widths, state encoding and clog2 helper for the CIC compensation FIR.
// Default widths match the upstream CIC so both instantiations agree.
package cic_comp_fir_pkg;

    localparam int CF_IN_WIDTH   = 24;
    localparam int CF_OUT_WIDTH  = 24;
    localparam int CF_COEF_WIDTH = 18;

    typedef enum logic [1:0] {
        CF_CLEAR = 2'd0,
        CF_IDLE  = 2'd1,
        CF_MAC   = 2'd2,
        CF_ROUND = 2'd3
    } cf_state_e;

    function automatic int cf_clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/cic_comp_fir_rom.sv
// Coefficient ROM, NTAPS x COEF_WIDTH, one-cycle registered read.
// Coefficients arrive packed in COEF_INIT, tap i at bits [i*COEF_WIDTH +: COEF_WIDTH].
module cic_comp_fir_rom
    import cic_comp_fir_pkg::*;
#(
    parameter int                            NTAPS      = 32,
    parameter int                            COEF_WIDTH = 18,
    parameter logic [NTAPS*COEF_WIDTH-1:0]   COEF_INIT  = '0,
    localparam int                           AW         = cf_clog2(NTAPS)
) (
    input  logic                         clk_i,
    input  logic [AW-1:0]                addr_i,
    output logic signed [COEF_WIDTH-1:0] data_o
);

    logic signed [COEF_WIDTH-1:0] rom [2**AW];
    logic signed [COEF_WIDTH-1:0] data_q;

    for (genvar i = 0; i < 2**AW; i++) begin : g_rom
        if (i < NTAPS) begin : g_tap
            assign rom[i] = COEF_INIT[i*COEF_WIDTH +: COEF_WIDTH];
        end else begin : g_pad
            assign rom[i] = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        data_q <= rom[addr_i];
    end

    assign data_o = data_q;

endmodule

// File: rtl/cic_comp_fir.sv
// Serial-MAC CIC droop compensation FIR with optional decimate-by-2; out_strobe at trigger+NTAPS+3.
// No backpressure: ready only drops during post-reset clear; CIC_COMP_FIR_SAT_EN selects clamp vs wrap.
module cic_comp_fir
    import cic_comp_fir_pkg::*;
#(
    parameter int IN_WIDTH   = CF_IN_WIDTH,
    parameter int OUT_WIDTH  = CF_OUT_WIDTH,
    parameter int COEF_WIDTH = CF_COEF_WIDTH,
    parameter int NTAPS      = 32,
    parameter int DECIM      = 2,
    parameter logic [NTAPS*COEF_WIDTH-1:0] COEF_INIT =
        {{(NTAPS*COEF_WIDTH-COEF_WIDTH+1){1'b0}}, {(COEF_WIDTH-1){1'b1}}}
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        in_strobe,
    input  logic signed [IN_WIDTH-1:0]  in_data,
    output logic                        ready,
    output logic                        out_strobe,
    output logic signed [OUT_WIDTH-1:0] out_data,
    output logic                        busy,
    output logic                        overrun
);

    localparam int TAP_AW    = cf_clog2(NTAPS);
    localparam int ACC_WIDTH = IN_WIDTH + COEF_WIDTH + TAP_AW;
    localparam int BUF_AW    = cf_clog2(2 * NTAPS);
    localparam int BUF_DEPTH = 2**BUF_AW;
    localparam int SH        = ACC_WIDTH - TAP_AW - 1 - OUT_WIDTH;
    localparam int RW        = ACC_WIDTH - SH;

    cf_state_e                     state_q, state_d;
    logic [BUF_AW-1:0]             wr_ptr_q, wr_ptr_d;
    logic [BUF_AW-1:0]             base_q, base_d;
    logic [BUF_AW-1:0]             cnt_q, cnt_d;
    logic                          phase_q, phase_d;
    logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic signed [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                          out_strobe_q, out_strobe_d;
    logic                          overrun_q, overrun_d;

    logic signed [IN_WIDTH-1:0]    smp_mem [BUF_DEPTH];
    logic signed [IN_WIDTH-1:0]    rd_q;
    logic signed [COEF_WIDTH-1:0]  coef_q;
    logic signed [IN_WIDTH+COEF_WIDTH-1:0] prod;
    logic                          mem_we;
    logic [BUF_AW-1:0]             mem_wa;
    logic signed [IN_WIDTH-1:0]    mem_wd;
    logic [BUF_AW-1:0]             rd_addr;
    logic                          trigger;
    logic [RW-1:0]                 rnd_wide;
    logic signed [OUT_WIDTH-1:0]   rounded;
    logic                          unused_acc;

    assign ready   = (state_q != CF_CLEAR);
    assign busy    = (state_q == CF_MAC) || (state_q == CF_ROUND);
    assign trigger = in_strobe && ready && ((DECIM == 1) || phase_q);

    // Clearing owns the single write port until every buffer word is zero.
    assign mem_we  = !reset && (!ready || in_strobe);
    assign mem_wa  = ready ? wr_ptr_q : cnt_q;
    assign mem_wd  = ready ? in_data : '0;
    assign rd_addr = base_q - cnt_q;

    always_ff @(posedge clock) begin
        if (mem_we) smp_mem[mem_wa] <= mem_wd;
        rd_q <= smp_mem[rd_addr];
    end

    cic_comp_fir_rom #(
        .NTAPS      (NTAPS),
        .COEF_WIDTH (COEF_WIDTH),
        .COEF_INIT  (COEF_INIT)
    ) u_rom (
        .clk_i  (clock),
        .addr_i (cnt_q[TAP_AW-1:0]),
        .data_o (coef_q)
    );

    assign prod       = rd_q * coef_q;
    assign rnd_wide   = acc_q[ACC_WIDTH-1:SH] + RW'(acc_q[SH-1]);
    assign unused_acc = ^acc_q[SH-2:0];

`ifdef CIC_COMP_FIR_SAT_EN
    always_comb begin
        rounded = rnd_wide[OUT_WIDTH-1:0];
        if (!((&rnd_wide[RW-1:OUT_WIDTH-1]) || !(|rnd_wide[RW-1:OUT_WIDTH-1]))) begin
            rounded = rnd_wide[RW-1] ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                                     : {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_rnd;
    assign rounded    = rnd_wide[OUT_WIDTH-1:0];
    assign unused_rnd = ^rnd_wide[RW-1:OUT_WIDTH];
`endif

    always_comb begin
        state_d      = state_q;
        wr_ptr_d     = wr_ptr_q;
        base_d       = base_q;
        cnt_d        = cnt_q;
        phase_d      = phase_q;
        acc_d        = acc_q;
        out_data_d   = out_data_q;
        out_strobe_d = 1'b0;
        overrun_d    = overrun_q;

        if (ready && in_strobe) begin
            wr_ptr_d = wr_ptr_q + BUF_AW'(1);
            if (DECIM == 2) phase_d = ~phase_q;
        end
        if (trigger && busy) overrun_d = 1'b1;

        case (state_q)
            CF_CLEAR: begin
                cnt_d = cnt_q + BUF_AW'(1);
                if (cnt_q == BUF_AW'(BUF_DEPTH - 1)) begin
                    state_d = CF_IDLE;
                    cnt_d   = '0;
                end
            end
            CF_IDLE: begin
                if (trigger) begin
                    base_d  = wr_ptr_q;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CF_MAC;
                end
            end
            CF_MAC: begin
                // Read data lags the address by one cycle, so tap cnt-1 lands now.
                cnt_d = cnt_q + BUF_AW'(1);
                if (cnt_q != '0) acc_d = acc_q + ACC_WIDTH'(prod);
                if (cnt_q == BUF_AW'(NTAPS)) state_d = CF_ROUND;
            end
            CF_ROUND: begin
                out_data_d   = rounded;
                out_strobe_d = 1'b1;
                state_d      = CF_IDLE;
            end
            default: state_d = CF_CLEAR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= CF_CLEAR;
            wr_ptr_q     <= '0;
            base_q       <= '0;
            cnt_q        <= '0;
            phase_q      <= 1'b0;
            acc_q        <= '0;
            out_data_q   <= '0;
            out_strobe_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            base_q       <= base_d;
            cnt_q        <= cnt_d;
            phase_q      <= phase_d;
            acc_q        <= acc_d;
            out_data_q   <= out_data_d;
            out_strobe_q <= out_strobe_d;
            overrun_q    <= overrun_d;
        end
    end

    assign out_data   = out_data_q;
    assign out_strobe = out_strobe_q;
    assign overrun    = overrun_q;

endmodule

// File: tb/tb_cic_comp_fir.sv
// Bench for cic_comp_fir: three instances (ramp taps DECIM=1, flat taps DECIM=2, 1.5-gain taps DECIM=1)
// checked against an arithmetic convolution model of the sample history.
module tb_cic_comp_fir;

    typedef struct {
        int k;
        int cyc;
        int val;
    } ev_t;

    logic              clk;
    logic              rst  [3];
    logic              stb  [3];
    logic signed [23:0] din  [3];
    logic              rdy  [3];
    logic              ostb [3];
    logic signed [23:0] dout [3];
    logic              bsy  [3];
    logic              ovr  [3];

    int  cyc = 0;
    int  checks = 0;
    int  failures = 0;
    ev_t evq[$];
    ev_t expq[$];
    int  hist[$];
    int  last_acc;
    bit  exp_ovr;
    int  snap_ostb, snap_odat, snap_busy, snap_ovr, snap_rdy;

    function automatic int coef_of(input int k, input int i);
        if (k == 0) return i * 1024;
        if (k == 1) return 4096;
        return 6144;
    endfunction

    function automatic logic [575:0] mk_coefs(input int k);
        logic [575:0] v;
        v = '0;
        for (int i = 0; i < 32; i++) v[i*18 +: 18] = 18'(coef_of(k, i));
        return v;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        cic_comp_fir #(
            .IN_WIDTH   (24),
            .OUT_WIDTH  (24),
            .COEF_WIDTH (18),
            .NTAPS      (32),
            .DECIM      ((g == 1) ? 2 : 1),
            .COEF_INIT  (mk_coefs(g))
        ) u_dut (
            .clock      (clk),
            .reset      (rst[g]),
            .in_strobe  (stb[g]),
            .in_data    (din[g]),
            .ready      (rdy[g]),
            .out_strobe (ostb[g]),
            .out_data   (dout[g]),
            .busy       (bsy[g]),
            .overrun    (ovr[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++)
            if (ostb[k] === 1'b1) evq.push_back('{k: k, cyc: cyc, val: int'(dout[k])});
    end

    // Convolution of the last 32 samples since clear, rounded half-up at 2^-17.
    function automatic int model_out(input int k, input int n);
        longint acc, rnd, w;
        acc = 0;
        for (int i = 0; i < 32; i++)
            if (n - i >= 0) acc += longint'(coef_of(k, i)) * longint'(hist[n - i]);
        rnd = (acc + 65536) >>> 17;
`ifdef CIC_COMP_FIR_SAT_EN
        if (rnd > 8388607) rnd = 8388607;
        if (rnd < -8388608) rnd = -8388608;
        w = rnd;
`else
        w = rnd & 64'hFF_FFFF;
        if (w >= 8388608) w -= 16777216;
`endif
        return int'(w);
    endfunction

    task automatic clear_model();
        hist.delete();
        expq.delete();
        evq.delete();
        last_acc = -1000;
        exp_ovr  = 1'b0;
    endtask

    // Caller sits just after a negedge; returns after exactly gap cycles.
    task automatic send(input int k, input int data, input int gap);
        int idx, d;
        d = (k == 1) ? 2 : 1;
        stb[k] = 1'b1;
        din[k] = data[23:0];
        idx = hist.size();
        hist.push_back(data);
        if ((idx % d) == d - 1) begin
            if (cyc - last_acc >= 35) begin
                expq.push_back('{k: k, cyc: cyc + 35, val: model_out(k, idx)});
                last_acc = cyc;
            end else begin
                exp_ovr = 1'b1;
            end
        end
        @(negedge clk);
        stb[k] = 1'b0;
        din[k] = '0;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic do_reset(input int k, output int low_cnt, output int strobes);
        rst[k] = 1'b1;
        @(negedge clk);
        snap_ostb = int'(ostb[k]);
        snap_odat = int'(dout[k]);
        snap_busy = int'(bsy[k]);
        snap_ovr  = int'(ovr[k]);
        snap_rdy  = int'(rdy[k]);
        rst[k] = 1'b0;
        low_cnt = 0;
        strobes = 0;
        while (rdy[k] !== 1'b1 && low_cnt < 200) begin
            low_cnt++;
            if (ostb[k] === 1'b1) strobes++;
            @(negedge clk);
        end
        clear_model();
    endtask

    task automatic test_reset();
        int low, sc;
        do_reset(0, low, sc);
        checks++; if (snap_ostb !== 0) begin failures++; $display("FAIL reset_out_strobe: got %0d expected 0", snap_ostb); end
        checks++; if (snap_odat !== 0) begin failures++; $display("FAIL reset_out_data: got %0d expected 0", snap_odat); end
        checks++; if (snap_busy !== 0) begin failures++; $display("FAIL reset_busy: got %0d expected 0", snap_busy); end
        checks++; if (snap_ovr !== 0) begin failures++; $display("FAIL reset_overrun: got %0d expected 0", snap_ovr); end
        checks++; if (snap_rdy !== 0) begin failures++; $display("FAIL reset_ready: got %0d expected 0", snap_rdy); end
        checks++; if (low !== 64) begin failures++; $display("FAIL clear_length: got %0d cycles expected 64", low); end
        checks++; if (sc !== 0) begin failures++; $display("FAIL clear_strobes: got %0d expected 0", sc); end
    endtask

    task automatic test_impulse(input bit skip_reset);
        int low, sc, n, want;
        if (!skip_reset) do_reset(0, low, sc);
        send(0, 131072, 36);
        for (int j = 0; j < 33; j++) send(0, 0, 36);
        repeat (40) @(negedge clk);
        checks++;
        if (evq.size() !== 34) begin failures++; $display("FAIL impulse_count: got %0d expected 34", evq.size()); end
        n = (evq.size() < 34) ? evq.size() : 34;
        for (int j = 0; j < n; j++) begin
            want = (j < 32) ? j * 1024 : 0;
            checks++;
            if (evq[j].val !== want) begin failures++; $display("FAIL impulse_val[%0d]: got %0d expected %0d", j, evq[j].val, want); end
            checks++;
            if (evq[j].cyc !== expq[j].cyc) begin failures++; $display("FAIL impulse_lat[%0d]: got cycle %0d expected %0d", j, evq[j].cyc, expq[j].cyc); end
        end
    endtask

    task automatic test_dc_decim2();
        int low, sc, n;
        do_reset(1, low, sc);
        for (int j = 0; j < 40; j++) send(1, 4096, 18);
        repeat (40) @(negedge clk);
        checks++;
        if (evq.size() !== 20) begin failures++; $display("FAIL dc_count: got %0d expected 20", evq.size()); end
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int j = 0; j < n; j++) begin
            checks++;
            if (evq[j].val !== expq[j].val || evq[j].cyc !== expq[j].cyc)
                begin failures++; $display("FAIL dc_out[%0d]: got %0d@%0d expected %0d@%0d", j, evq[j].val, evq[j].cyc, expq[j].val, expq[j].cyc); end
            if (j >= 15) begin
                checks++;
                if (evq[j].val !== 4096) begin failures++; $display("FAIL dc_unity[%0d]: got %0d expected 4096", j, evq[j].val); end
            end
        end
    endtask

    task automatic test_overrun();
        int low, sc, n;
        do_reset(0, low, sc);
        checks++;
        if (ovr[0] !== 1'b0) begin failures++; $display("FAIL ovr_initial: got %0b expected 0", ovr[0]); end
        for (int j = 0; j < 12; j++) begin
            send(0, int'($urandom_range(16777215)) - 8388608, 8);
            if (j == 1) begin
                checks++;
                if (ovr[0] !== exp_ovr) begin failures++; $display("FAIL ovr_second_trigger: got %0b expected %0b", ovr[0], exp_ovr); end
            end
        end
        repeat (40) @(negedge clk);
        checks++;
        if (evq.size() !== expq.size()) begin failures++; $display("FAIL ovr_count: got %0d expected %0d", evq.size(), expq.size()); end
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int j = 0; j < n; j++) begin
            checks++;
            if (evq[j].val !== expq[j].val || evq[j].cyc !== expq[j].cyc)
                begin failures++; $display("FAIL ovr_out[%0d]: got %0d@%0d expected %0d@%0d", j, evq[j].val, evq[j].cyc, expq[j].val, expq[j].cyc); end
        end
        checks++;
        if (ovr[0] !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %0b expected 1", ovr[0]); end
    endtask

    task automatic test_saturation();
        int low, sc, n, want;
`ifdef CIC_COMP_FIR_SAT_EN
        want = 8388607;
`else
        want = -4194305;
`endif
        do_reset(2, low, sc);
        for (int j = 0; j < 34; j++) send(2, 8388607, 36);
        repeat (40) @(negedge clk);
        checks++;
        if (evq.size() !== 34) begin failures++; $display("FAIL sat_count: got %0d expected 34", evq.size()); end
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int j = 0; j < n; j++) begin
            checks++;
            if (evq[j].val !== expq[j].val) begin failures++; $display("FAIL sat_out[%0d]: got %0d expected %0d", j, evq[j].val, expq[j].val); end
        end
        if (evq.size() > 0) begin
            checks++;
            if (evq[evq.size()-1].val !== want) begin failures++; $display("FAIL sat_full_scale: got %0d expected %0d", evq[evq.size()-1].val, want); end
        end
    endtask

    task automatic test_random();
        int low, sc, n;
        do_reset(0, low, sc);
        for (int j = 0; j < 60; j++)
            send(0, int'($urandom_range(16777215)) - 8388608, int'($urandom_range(45, 1)));
        repeat (40) @(negedge clk);
        checks++;
        if (evq.size() !== expq.size()) begin failures++; $display("FAIL rand_count: got %0d expected %0d", evq.size(), expq.size()); end
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int j = 0; j < n; j++) begin
            checks++;
            if (evq[j].val !== expq[j].val || evq[j].cyc !== expq[j].cyc)
                begin failures++; $display("FAIL rand_out[%0d]: got %0d@%0d expected %0d@%0d", j, evq[j].val, evq[j].cyc, expq[j].val, expq[j].cyc); end
        end
        checks++;
        if (ovr[0] !== exp_ovr) begin failures++; $display("FAIL rand_overrun: got %0b expected %0b", ovr[0], exp_ovr); end
    endtask

    task automatic test_reset_mid_mac();
        int low, sc;
        do_reset(0, low, sc);
        send(0, 131072, 1);
        repeat (9) @(negedge clk);
        checks++;
        if (bsy[0] !== 1'b1) begin failures++; $display("FAIL mid_busy_before: got %0b expected 1", bsy[0]); end
        do_reset(0, low, sc);
        checks++; if (snap_busy !== 0) begin failures++; $display("FAIL mid_busy_after: got %0d expected 0", snap_busy); end
        checks++; if (snap_ostb !== 0) begin failures++; $display("FAIL mid_strobe_after: got %0d expected 0", snap_ostb); end
        checks++; if (low !== 64) begin failures++; $display("FAIL mid_clear_length: got %0d expected 64", low); end
        checks++; if (sc !== 0) begin failures++; $display("FAIL mid_clear_strobes: got %0d expected 0", sc); end
        repeat (40) @(negedge clk);
        checks++;
        if (evq.size() !== 0) begin failures++; $display("FAIL mid_no_output: got %0d strobes expected 0", evq.size()); end
        clear_model();
        test_impulse(1'b1);
    endtask

    initial begin
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1;
            stb[k] = 1'b0;
            din[k] = '0;
        end
        repeat (3) @(negedge clk);
        test_reset();
        test_impulse(1'b0);
        test_dc_decim2();
        test_overrun();
        test_saturation();
        test_random();
        test_reset_mid_mac();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
